// File: rtl/vector_pkg.sv
// Shared types and constants for the vector capture monitor.
// Holds the segment entry layout, tracker states and default sizing.
package vector_pkg;

    localparam int VEC_W          = 8;
    localparam int DEFAULT_DEPTH  = 8;
    localparam int DEFAULT_HOLD_W = 16;

    typedef struct packed {
        logic [VEC_W-1:0]          value;
        logic [DEFAULT_HOLD_W-1:0] hold;
    } seg_entry_t;

    // BASE: no reference value yet; TRACK: cur_val/hold describe a live segment.
    typedef enum logic {
        ST_BASE  = 1'b0,
        ST_TRACK = 1'b1
    } track_state_t;

    function automatic logic vec_parity(input logic [VEC_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/vector_capture_fifo.sv
// Synchronous FIFO of segment entries with registered read and a one-cycle
// rd_valid pulse; empty/full are registered from the post-edge occupancy.
module vector_capture_fifo
    import vector_pkg::*;
#(
    parameter int  DEPTH   = DEFAULT_DEPTH,
    parameter type entry_t = seg_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t rd_data,
    output logic   rd_valid,
    output logic   empty,
    output logic   full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;
    entry_t           mem [DEPTH];

    // A pop frees a slot in the same edge, so a full FIFO can still take a push.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // NOTE: storage has no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/vector_capture.sv
// Segment capture monitor: records each stable run of data_in as {value, hold}
// into a FIFO. Define VECTOR_CAPTURE_PARITY_EN to add the rd_parity output.
module vector_capture
    import vector_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int HOLD_W = DEFAULT_HOLD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VEC_W-1:0]  data_in,
    input  logic              flush,
    input  logic              rd_en,
    output logic [VEC_W-1:0]  rd_value,
    output logic [HOLD_W-1:0] rd_hold,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic [7:0]        seg_cnt
`ifdef VECTOR_CAPTURE_PARITY_EN
    ,
    output logic              rd_parity
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};

    typedef struct packed {
`ifdef VECTOR_CAPTURE_PARITY_EN
        logic              parity;
`endif
        logic [VEC_W-1:0]  value;
        logic [HOLD_W-1:0] hold;
    } entry_t;

    track_state_t      state;
    track_state_t      state_next;
    logic [VEC_W-1:0]  cur_val;
    logic [HOLD_W-1:0] hold;
    logic              load;
    logic              count_up;
    logic              push;
    entry_t            push_data;
    entry_t            rd_data;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        count_up   = 1'b0;
        push       = 1'b0;
        case (state)
            ST_BASE: begin
                load       = 1'b1;
                state_next = ST_TRACK;
            end
            ST_TRACK: begin
                if ((data_in != cur_val) || flush) begin
                    push = 1'b1;
                    load = 1'b1;
                end else begin
                    count_up = 1'b1;
                end
            end
            default: state_next = ST_BASE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BASE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_val <= '0;
            hold    <= '0;
        end else if (load) begin
            cur_val <= data_in;
            hold    <= HOLD_W'(1);
        end else if (count_up && (hold != HOLD_MAX)) begin
            hold <= hold + HOLD_W'(1);
        end
    end

    always_comb begin
        push_data       = '0;
        push_data.value = cur_val;
        push_data.hold  = hold;
`ifdef VECTOR_CAPTURE_PARITY_EN
        push_data.parity = vec_parity(cur_val);
`endif
    end

    // A dropped push still counts as a segment; only the entry is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            seg_cnt  <= '0;
        end else if (push) begin
            seg_cnt <= seg_cnt + 8'd1;
            if (full && !rd_en) begin
                overflow <= 1'b1;
            end
        end
    end

    vector_capture_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full)
    );

    assign rd_value = rd_data.value;
    assign rd_hold  = rd_data.hold;
`ifdef VECTOR_CAPTURE_PARITY_EN
    assign rd_parity = rd_data.parity;
`endif

endmodule

// File: tb/tb_vector_capture.sv
// Directed self-checking bench for vector_capture; a second instance with
// HOLD_W=4 shares the stimulus to exercise hold saturation.
module tb_vector_capture;
    import vector_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = '0;
    logic        flush = 1'b0;
    logic        rd_en = 1'b0;

    logic [7:0]  rd_value, rd_value4;
    logic [15:0] rd_hold;
    logic [3:0]  rd_hold4;
    logic        rd_valid, rd_valid4;
    logic        empty, empty4, full, full4, overflow, overflow4;
    logic [7:0]  seg_cnt, seg_cnt4;
`ifdef VECTOR_CAPTURE_PARITY_EN
    logic        rd_parity, rd_parity4;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vector_capture u_dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .flush    (flush),
        .rd_en    (rd_en),
        .rd_value (rd_value),
        .rd_hold  (rd_hold),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .seg_cnt  (seg_cnt)
`ifdef VECTOR_CAPTURE_PARITY_EN
        ,
        .rd_parity (rd_parity)
`endif
    );

    vector_capture #(.DEPTH(8), .HOLD_W(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .flush    (flush),
        .rd_en    (rd_en),
        .rd_value (rd_value4),
        .rd_hold  (rd_hold4),
        .rd_valid (rd_valid4),
        .empty    (empty4),
        .full     (full4),
        .overflow (overflow4),
        .seg_cnt  (seg_cnt4)
`ifdef VECTOR_CAPTURE_PARITY_EN
        ,
        .rd_parity (rd_parity4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_val(input logic [7:0] v, input int n);
        data_in = v;
        cycles(n);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rd_en = 1'b0;
        flush = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] v, input logic [15:0] h);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check({tag, " valid"}, 32'(rd_valid), 32'd1);
        check({tag, " value"}, 32'(rd_value), 32'(v));
        check({tag, " hold"},  32'(rd_hold),  32'(h));
`ifdef VECTOR_CAPTURE_PARITY_EN
        check({tag, " parity"}, 32'(rd_parity), 32'(^v));
`endif
    endtask

    initial begin
        logic [7:0] seq_vals [5];
        logic [7:0] v;
        seq_vals = '{8'hf3, 8'haa, 8'h55, 8'h6d, 8'hfc};

        @(negedge clk);

        // Reset state
        do_reset();
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst rd_value", 32'(rd_value), 32'd0);
        check("rst rd_hold",  32'(rd_hold),  32'd0);
        check("rst empty",    32'(empty),    32'd1);
        check("rst full",     32'(full),     32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst seg_cnt",  32'(seg_cnt),  32'd0);

        // Five 20-cycle segments closed by a final flush
        for (int i = 0; i < 5; i++) hold_val(seq_vals[i], 20);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        check("seq seg_cnt", 32'(seg_cnt), 32'd5);
        check("seq empty",   32'(empty),   32'd0);
        for (int i = 0; i < 5; i++) pop_check($sformatf("seq%0d", i), seq_vals[i], 16'd20);
        check("seq drained empty", 32'(empty), 32'd1);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check("pop empty rd_valid", 32'(rd_valid), 32'd0);
        check("pop empty keeps value", 32'(rd_value), 32'hfc);
        check("pop empty keeps hold",  32'(rd_hold),  32'd20);

        // Fill to full, swap with simultaneous push/pop, then drop one
        do_reset();
        for (int i = 0; i < 9; i++) begin
            v = 8'h10 + 8'(i);
            hold_val(v, 2);
        end
        check("fill full",     32'(full),     32'd1);
        check("fill overflow", 32'(overflow), 32'd0);
        check("fill seg_cnt",  32'(seg_cnt),  32'd8);
        data_in = 8'h19;
        rd_en   = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check("swap rd_valid", 32'(rd_valid), 32'd1);
        check("swap rd_value", 32'(rd_value), 32'h10);
        check("swap full",     32'(full),     32'd1);
        check("swap overflow", 32'(overflow), 32'd0);
        check("swap seg_cnt",  32'(seg_cnt),  32'd9);
        cycles(1);
        data_in = 8'h1a;
        cycles(1);
        check("drop overflow", 32'(overflow), 32'd1);
        check("drop seg_cnt",  32'(seg_cnt),  32'd10);
        for (int i = 1; i < 9; i++) begin
            v = 8'h10 + 8'(i);
            pop_check($sformatf("full%0d", i), v, 16'd2);
        end
        check("full drained empty", 32'(empty), 32'd1);

        // Hold saturation on the narrow instance
        do_reset();
        hold_val(8'h55, 30);
        data_in = 8'h66;
        cycles(1);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check("sat wide hold",    32'(rd_hold),   32'd30);
        check("sat narrow valid", 32'(rd_valid4), 32'd1);
        check("sat narrow value", 32'(rd_value4), 32'h55);
        check("sat narrow hold",  32'(rd_hold4),  32'd15);

        // Pop into an empty FIFO in the same cycle as the first push
        do_reset();
        hold_val(8'h77, 3);
        data_in = 8'h78;
        rd_en   = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check("first push rd_valid", 32'(rd_valid), 32'd0);
        check("first push empty",    32'(empty),    32'd0);
        pop_check("first push", 8'h77, 16'd3);

        // Reset during a pop with three entries queued
        do_reset();
        hold_val(8'h01, 2);
        hold_val(8'h02, 2);
        hold_val(8'h03, 2);
        hold_val(8'h04, 1);
        check("midrst seg_cnt before", 32'(seg_cnt), 32'd3);
        rst   = 1'b1;
        rd_en = 1'b1;
        cycles(1);
        rst   = 1'b0;
        rd_en = 1'b0;
        check("midrst rd_valid", 32'(rd_valid), 32'd0);
        check("midrst empty",    32'(empty),    32'd1);
        check("midrst overflow", 32'(overflow), 32'd0);
        check("midrst seg_cnt",  32'(seg_cnt),  32'd0);
        hold_val(8'h44, 1);
        hold_val(8'h45, 1);
        pop_check("midrst baseline", 8'h44, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vector_capture.md
Name: vector_capture

Overview:
- Receive-side counterpart to the vector stimulus stream: monitors an 8-bit data vector bus and records each completed stable segment as a {value, hold-cycles} pair.
- Segments are queued in a small FIFO and read out over a simple rd_en/rd_valid handshake.
- Sits beside the vector operator block as a synthesizable capture/replay monitor, so stimulus sequences can be checked on hardware.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- HOLD_W, 16, width of the hold-cycle counter; the counter saturates.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  8  monitored vector bus, sampled every clk.
- flush  in  1  force-close the current segment (push it without a data change).
- rd_en  in  1  pop request.
- rd_value  out  8  popped segment value.
- rd_hold  out  HOLD_W  popped segment length in cycles.
- rd_valid  out  1  rd_value/rd_hold valid this cycle (single-cycle pulse).
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- overflow  out  1  sticky: a segment was dropped.
- seg_cnt  out  8  total segments pushed since reset; wraps modulo 256.

Behaviour:
- Reset is synchronous and active-high; one clock, clk.
- Reset values: rd_value=0, rd_hold=0, rd_valid=0, empty=1, full=0, overflow=0, seg_cnt=0. Internally, base_valid=0 and FIFO pointers are cleared.
- Tracker state: BASE (base_valid=0) and TRACK (base_valid=1).
- BASE: the first edge with rst=0 loads cur_val=data_in and hold=1, then moves to TRACK. flush is ignored in BASE.
- TRACK, data_in==cur_val and flush=0: hold=min(hold+1, 2^HOLD_W-1). Saturates and never wraps.
- TRACK, data_in!=cur_val or flush=1: push {cur_val, hold}, then cur_val=data_in and hold=1.
- Change and flush in the same cycle produce exactly one push.
- Push when full with no pop in the same cycle: entry dropped, overflow=1, seg_cnt still increments. overflow clears only on rst.
- Pop: rd_en=1 while empty=0 pops the head. rd_value/rd_hold are registered, and rd_valid=1 on the next cycle (latency 1). rd_value/rd_hold hold their last popped value otherwise.
- rd_en while empty: ignored, rd_valid stays 0, no error.
- Push and pop in the same cycle when full: both accepted, occupancy unchanged, no overflow.
- Push and pop in the same cycle when empty: the pop is ignored and the push lands; empty deasserts on the next cycle.
- empty/full are registered from occupancy and reflect the state after the current edge's operations.
- rst asserted mid-operation: all queued entries are discarded, and a pop in flight does not produce rd_valid on the following cycle.

Optional Feature:
- Macro VECTOR_CAPTURE_PARITY_EN.
- Defined: adds output rd_parity (1 bit) = XOR-reduction of the popped rd_value, registered alongside rd_value. It is stored per entry at push time; reset value 0.
- Undefined: the port and its storage are absent, and all other behaviour is identical.

Decomposition:
- Package vector_pkg holds:
  - VEC_W=8.
  - Default DEPTH and HOLD_W constants.
  - Typedef seg_entry_t {value[VEC_W-1:0], hold[HOLD_W-1:0]}.
- One natural sub-module, vector_capture_fifo: a synchronous FIFO of seg_entry_t with push, pop, empty, full and registered read. The segment tracker and counters stay in vector_capture.

Test Plan:
- Sequence: rst 2 cycles, then data_in=f3 for 20 cycles, aa 20, 55 20, 6d 20, fc 20, then flush -> FIFO holds (f3,20) (aa,20) (55,20) (6d,20) (fc,20); seg_cnt=5. Popping 5 times returns them in order, each with rd_valid one cycle after rd_en.
- DEPTH=8: push 9 segments with no reads -> full=1 after the 8th push, overflow=1 after the 9th, and the 9th entry is lost (pops return the first 8); seg_cnt=9.
- Full FIFO with a simultaneous change and rd_en -> occupancy stays 8, overflow stays 0, the new segment appears last.
- HOLD_W=4: hold data_in=55 for 30 cycles, then change -> entry (55,15).
- rd_en while empty -> rd_valid=0. rd_en together with the first push into an empty FIFO -> empty=0 next cycle, and the entry pops on a later rd_en.
- rst asserted during rd_en with 3 entries queued -> no rd_valid on the next cycle; empty=1, overflow=0, seg_cnt=0. The next sample after rst deasserts starts a new baseline with hold=1.
